// File: rtl/ifetch_line_if.sv
// Fetch-unit bus bundle: the instruction output channel (valid/ready) and the
// line-read channel (AR request handshake plus an un-throttled R data pulse).
// Ports: master = fetch unit (drives inst_*, ar*), slave = consumer/memory side.
interface ifetch_line_if;
   logic         inst_valid;
   logic         inst_ready;
   logic [31:0]  inst;
   logic [31:0]  inst_pc;
   logic [31:0]  araddr;
   logic         arvalid;
   logic         arready;
   logic [127:0] rdata;
   logic         rvalid;

   modport master (
      output inst_valid, inst, inst_pc, araddr, arvalid,
      input  inst_ready, arready, rdata, rvalid
   );

   modport slave (
      input  inst_valid, inst, inst_pc, araddr, arvalid,
      output inst_ready, arready, rdata, rvalid
   );
endinterface

// File: rtl/ifetch_line.sv
// Purpose: single-line instruction fetcher; reads a 16-byte line, hands out its words in order.
// Latency: first word valid one cycle after the R pulse; one word per cycle while inst_ready=1.
// Backpressure: inst_ready=0 holds the current word and issues no read; AR held until arready.
// Ports: clk, rst (async, active high); pc_set/pc_new redirect strobe and target;
//        bus (master) carries inst_valid/inst_ready/inst/inst_pc and araddr/arvalid/arready/rdata/rvalid.
module ifetch_line #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pc_set,
   input  logic [31:0]         pc_new,
   ifetch_line_if.master       bus
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, HAVE} state_t;

   state_t         state, state_nxt;
   logic [31:0]    pc, pc_nxt;
   logic [31:0]    araddr_q, araddr_nxt;
   logic [127:0]   line, line_nxt;
   logic           stale, stale_nxt;

   // The redirect target is word aligned; its low two bits carry no meaning.
   logic           unused_pc_lsb;
   assign unused_pc_lsb = ^pc_new[1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         araddr_q <= 32'h0;
         line     <= 128'h0;
         stale    <= 1'b0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         araddr_q <= araddr_nxt;
         line     <= line_nxt;
         stale    <= stale_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc;
      line_nxt   = line;
      stale_nxt  = stale;
      araddr_nxt = araddr_q;

      // A redirect always wins over the instruction handshake.
      if (pc_set) begin
         pc_nxt = {pc_new[31:2], 2'b00};
      end

      case (state)
         IDLE: begin
            state_nxt = REQ;
         end
         REQ: begin
            // The AR in flight keeps its old address; its data must be dropped later.
            if (pc_set) begin
               stale_nxt = 1'b1;
            end
            if (bus.arready) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (bus.rvalid) begin
               stale_nxt = 1'b0;
               if (stale || pc_set) begin
                  state_nxt = REQ;
               end else begin
                  line_nxt  = bus.rdata;
                  state_nxt = HAVE;
               end
            end else if (pc_set) begin
               stale_nxt = 1'b1;
            end
         end
         HAVE: begin
            if (pc_set) begin
               state_nxt = REQ;
            end else if (bus.inst_ready) begin
               pc_nxt = pc + 32'd4;
               if (pc[3:2] == 2'b11) begin
                  state_nxt = REQ;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Line address is frozen on entry to REQ so it stays stable across redirects.
      if ((state_nxt == REQ) && (state != REQ)) begin
         araddr_nxt = {pc_nxt[31:4], 4'h0};
      end
   end

   always_comb begin
      case (pc[3:2])
         2'd0:    bus.inst = line[31:0];
         2'd1:    bus.inst = line[63:32];
         2'd2:    bus.inst = line[95:64];
         default: bus.inst = line[127:96];
      endcase
   end

   assign bus.inst_valid = (state == HAVE);
   assign bus.inst_pc    = pc;
   assign bus.arvalid    = (state == REQ);
   assign bus.araddr     = araddr_q;

endmodule

// File: tb/tb_ifetch_line.sv
// Scoreboard bench for ifetch_line: directed redirect/backpressure/reset scenarios.
module tb_ifetch_line;

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_set;
   logic [31:0] pc_new;

   ifetch_line_if bus ();

   ifetch_line #(.RESET_PC(32'h8000_0000)) dut (
      .clk    (clk),
      .rst    (rst),
      .pc_set (pc_set),
      .pc_new (pc_new),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } inst_exp_t;

   logic [31:0] exp_ar[$];
   inst_exp_t   exp_inst[$];
   int          n_chk  = 0;
   int          n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for the AR handshake and returns just after its edge.
   task automatic wait_ar();
      int n;
      n = 0;
      while (!(bus.arvalid && bus.arready)) begin
         step();
         n++;
         if (n > 20) begin
            n_chk++;
            n_fail++;
            $display("FAIL ar_timeout: got no AR handshake, expected one within 20 cycles");
            return;
         end
      end
      step();
   endtask

   task automatic rpulse(input logic [127:0] d);
      bus.rdata  = d;
      bus.rvalid = 1'b1;
      step();
      bus.rvalid = 1'b0;
   endtask

   function automatic logic [127:0] line_of(input logic [31:0] a);
      return {a + 32'd12, a + 32'd8, a + 32'd4, a};
   endfunction

   task automatic push_inst(input logic [31:0] i, input logic [31:0] p);
      inst_exp_t e;
      e.inst = i;
      e.pc   = p;
      exp_inst.push_back(e);
   endtask

   // Monitor: compares every accepted AR and every consumed instruction.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.arvalid && bus.arready) begin
            if (exp_ar.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL ar_unexpected: got araddr %h, expected no request", bus.araddr);
            end else begin
               chk("araddr", bus.araddr, exp_ar.pop_front());
            end
         end
         if (bus.inst_valid && bus.inst_ready) begin
            if (exp_inst.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL inst_unexpected: got inst %h pc %h, expected none", bus.inst, bus.inst_pc);
            end else begin
               inst_exp_t e;
               e = exp_inst.pop_front();
               chk("inst", bus.inst, e.inst);
               chk("inst_pc", bus.inst_pc, e.pc);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_arvalid"},    {31'h0, bus.arvalid},    32'h0);
      chk({tag, "_araddr"},     bus.araddr,              32'h0);
      chk({tag, "_inst_valid"}, {31'h0, bus.inst_valid}, 32'h0);
      chk({tag, "_inst"},       bus.inst,                32'h0);
      chk({tag, "_inst_pc"},    bus.inst_pc,             32'h8000_0000);
   endtask

   initial begin
      rst            = 1'b1;
      pc_set         = 1'b0;
      pc_new         = 32'h0;
      bus.inst_ready = 1'b0;
      bus.arready    = 1'b0;
      bus.rvalid     = 1'b0;
      bus.rdata      = 128'h0;
      step();
      step();
      chk_reset_outputs("rst");

      // First line after reset, streamed with inst_ready held high.
      exp_ar.push_back(32'h8000_0000);
      bus.arready = 1'b1;
      rst         = 1'b0;
      wait_ar();
      push_inst(32'h0000_000A, 32'h8000_0000);
      push_inst(32'h0000_000B, 32'h8000_0004);
      push_inst(32'h0000_000C, 32'h8000_0008);
      push_inst(32'h0000_000D, 32'h8000_000C);
      exp_ar.push_back(32'h8000_0010);
      bus.inst_ready = 1'b1;
      rpulse(128'h0000000D_0000000C_0000000B_0000000A);
      chk("inst_valid_latency", {31'h0, bus.inst_valid}, 32'h1);
      repeat (4) step();
      bus.inst_ready = 1'b0;
      wait_ar();
      rpulse(line_of(32'h8000_0010));

      // Consumer stall: outputs frozen, no read issued.
      for (int i = 0; i < 5; i++) begin
         chk("stall_inst_valid", {31'h0, bus.inst_valid}, 32'h1);
         chk("stall_inst",       bus.inst,                32'h8000_0010);
         chk("stall_inst_pc",    bus.inst_pc,             32'h8000_0010);
         chk("stall_arvalid",    {31'h0, bus.arvalid},    32'h0);
         step();
      end
      push_inst(32'h8000_0010, 32'h8000_0010);
      bus.inst_ready = 1'b1;
      step();
      bus.inst_ready = 1'b0;

      // Redirect in HAVE to an unaligned target.
      pc_set = 1'b1;
      pc_new = 32'h8000_0109;
      step();
      pc_set = 1'b0;
      chk("redir_have_inst_valid", {31'h0, bus.inst_valid}, 32'h0);
      exp_ar.push_back(32'h8000_0100);
      wait_ar();
      push_inst(32'h8000_0108, 32'h8000_0108);
      rpulse(line_of(32'h8000_0100));
      bus.inst_ready = 1'b1;
      step();
      push_inst(32'h8000_010C, 32'h8000_010C);
      exp_ar.push_back(32'h8000_0110);
      step();
      bus.inst_ready = 1'b0;

      // Redirect in WAIT: the in-flight line is dropped.
      wait_ar();
      pc_set = 1'b1;
      pc_new = 32'h8000_0200;
      step();
      pc_set = 1'b0;
      exp_ar.push_back(32'h8000_0200);
      rpulse(line_of(32'h8000_0110));
      chk("redir_wait_inst_valid", {31'h0, bus.inst_valid}, 32'h0);
      wait_ar();
      push_inst(32'h8000_0200, 32'h8000_0200);
      rpulse(line_of(32'h8000_0200));
      bus.inst_ready = 1'b1;
      step();
      bus.inst_ready = 1'b0;

      // Redirect while the AR is stalled: address held, response dropped.
      bus.arready = 1'b0;
      pc_set      = 1'b1;
      pc_new      = 32'h8000_0000;
      step();
      pc_set = 1'b0;
      chk("ar_hold1_arvalid", {31'h0, bus.arvalid}, 32'h1);
      chk("ar_hold1_araddr",  bus.araddr,           32'h8000_0000);
      step();
      chk("ar_hold2_araddr",  bus.araddr,           32'h8000_0000);
      pc_set = 1'b1;
      pc_new = 32'h8000_0300;
      step();
      pc_set = 1'b0;
      chk("ar_hold3_araddr",  bus.araddr,           32'h8000_0000);
      chk("ar_hold3_arvalid", {31'h0, bus.arvalid}, 32'h1);
      step();
      exp_ar.push_back(32'h8000_0000);
      exp_ar.push_back(32'h8000_0300);
      bus.arready = 1'b1;
      wait_ar();
      rpulse(line_of(32'h8000_0000));
      chk("stale_drop_inst_valid", {31'h0, bus.inst_valid}, 32'h0);
      wait_ar();
      push_inst(32'h8000_0300, 32'h8000_0300);
      rpulse(line_of(32'h8000_0300));
      bus.inst_ready = 1'b1;
      step();
      bus.inst_ready = 1'b0;

      // PC wrap from the top of the address space.
      pc_set = 1'b1;
      pc_new = 32'hFFFF_FFFC;
      step();
      pc_set = 1'b0;
      exp_ar.push_back(32'hFFFF_FFF0);
      wait_ar();
      push_inst(32'hFFFF_FFFC, 32'hFFFF_FFFC);
      exp_ar.push_back(32'h0000_0000);
      rpulse(line_of(32'hFFFF_FFF0));
      bus.inst_ready = 1'b1;
      step();
      bus.inst_ready = 1'b0;
      chk("wrap_inst_pc", bus.inst_pc, 32'h0000_0000);
      wait_ar();
      push_inst(32'h0000_0000, 32'h0000_0000);
      rpulse(line_of(32'h0000_0000));
      bus.inst_ready = 1'b1;
      step();
      bus.inst_ready = 1'b0;

      // Reset in the middle of WAIT, then a late R pulse that must be ignored.
      pc_set = 1'b1;
      pc_new = 32'h8000_0400;
      step();
      pc_set = 1'b0;
      exp_ar.push_back(32'h8000_0400);
      wait_ar();
      step();
      rst = 1'b1;
      #1;
      chk_reset_outputs("midwait_rst");
      step();
      exp_ar.push_back(32'h8000_0000);
      rst        = 1'b0;
      bus.rdata  = line_of(32'h8000_0400);
      bus.rvalid = 1'b1;
      step();
      bus.rvalid = 1'b0;
      chk("post_rst_inst_valid", {31'h0, bus.inst_valid}, 32'h0);
      wait_ar();
      step();
      chk("post_rst_wait_inst_valid", {31'h0, bus.inst_valid}, 32'h0);

      chk("ar_queue_empty",   exp_ar.size(),   32'h0);
      chk("inst_queue_empty", exp_inst.size(), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ifetch_line.md
IFETCH_LINE -- requirements
Module: ifetch_line

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, is the fetch PC loaded by reset.
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 PC_SET  input  1  redirect strobe, one cycle.
REQ-005 PC_NEW  input  32  redirect target; bits [1:0] are ignored and treated as 0.
REQ-006 INST_VALID  output  1  instruction word available.
REQ-007 INST_READY  input  1  consumer accepts the instruction word.
REQ-008 INST  output  32  instruction word.
REQ-009 INST_PC  output  32  address of INST.
REQ-010 ARADDR  output  32  read line address, 16-byte aligned.
REQ-011 ARVALID  output  1  read request valid.
REQ-012 ARREADY  input  1  read request accepted.
REQ-013 RDATA  input  128  line data; word k = RDATA[32k+31:32k] is the word at line address + 4k.
REQ-014 RVALID  input  1  one-cycle data pulse; there is no backpressure, so RDATA is sampled whenever RVALID=1 in WAIT.

Function
REQ-015 States: IDLE, REQ, WAIT, HAVE.
- Registers: PC (32), line buffer (128), stale flag.
- At most one read is outstanding.
REQ-016 IDLE->REQ unconditionally on the first edge after RST deasserts.
REQ-017 REQ:
- ARVALID=1; ARADDR={PC[31:4],4'h0}, captured on REQ entry.
- ARADDR and ARVALID are held stable until ARVALID&&ARREADY.
- On handshake, go to WAIT.
REQ-018 WAIT, on RVALID=1:
- If stale=1 or PC_SET=1 in the same cycle: discard RDATA, clear stale, go to REQ.
- Otherwise: load the line buffer with RDATA and go to HAVE.
REQ-019 HAVE:
- INST_VALID=1; INST=line word PC[3:2]; INST_PC=PC.
- INST_VALID rises the cycle after the RVALID edge; latency is one cycle.
REQ-020 In HAVE, on INST_VALID&&INST_READY: PC<=PC+4, modulo 2^32.
- If the old PC[3:2]==2'b11, go to REQ for the next line.
- Otherwise stay in HAVE.
- 32'hFFFF_FFFC+4 wraps to 0.
REQ-021 With INST_READY=0, INST, INST_PC and INST_VALID hold, and no AR is issued.
REQ-022 PC_SET has priority over the instruction handshake: PC<={PC_NEW[31:2],2'b00}.
- A handshake in the PC_SET cycle counts as transferred to the consumer, but it does not advance PC.
REQ-023 PC_SET in HAVE: line invalidated; go to REQ; INST_VALID=0 from the next cycle.
REQ-024 PC_SET in REQ: the pending AR keeps its old address until accepted, and stale is set.
- If stale=1 when the AR is accepted, the block proceeds to WAIT and discards the response (REQ-018).
- After the discard, REQ issues the redirected line.
REQ-025 PC_SET in WAIT sets stale (REQ-018).
- PC_SET in IDLE loads PC only.
REQ-026 RVALID outside WAIT is ignored.
REQ-027 A new PC_SET while stale=1 overwrites PC; only the last target is fetched.
REQ-028 The first INST after any redirect is line word PC_NEW[3:2].

Reset
REQ-029 While RST=1:
- state=IDLE; PC=RESET_PC; stale=0; line buffer=0.
- ARVALID=0, ARADDR=0, INST_VALID=0, INST=0, INST_PC=RESET_PC.
REQ-030 RST asserted mid-transaction aborts it immediately.
- An RVALID arriving after release is ignored (REQ-026), since the block is then in IDLE or REQ.

Verification
REQ-031 Reset release, ARREADY=1, RVALID one cycle after AR with RDATA=128'h0000000D_0000000C_0000000B_0000000A -> ARADDR=32'h8000_0000; the next cycle INST_VALID=1, INST=32'h0000000A, INST_PC=32'h8000_0000.
REQ-032 INST_READY held 1 -> INST 0A,0B,0C,0D at INST_PC ...00/04/08/0C on consecutive cycles, then ARVALID=1 with ARADDR=32'h8000_0010.
REQ-033 PC_SET with PC_NEW=32'h8000_0109 in HAVE -> INST_VALID=0 next cycle; ARADDR=32'h8000_0100; first INST=RDATA[95:64], INST_PC=32'h8000_0108.
REQ-034 PC_SET with PC_NEW=32'h8000_0200 in WAIT -> that response is discarded (INST_VALID stays 0); next ARADDR=32'h8000_0200.
REQ-035 ARREADY=0 for 3 cycles, with PC_SET 32'h8000_0300 in cycle 2 -> ARADDR=32'h8000_0000 stable until accept; its response is discarded; then ARADDR=32'h8000_0300.
REQ-036 INST_READY=0 for 5 cycles in HAVE -> INST and INST_PC stable, ARVALID=0; RST pulse mid-WAIT -> all outputs at reset values, and the first AR after release is 32'h8000_0000.
